// File: rtl/glitch_sweep_seq.sv
// -----------------------------------------------------------------------------
// glitch_sweep_seq
//
// Sweep controller for the clock-glitch core. For every (clkcnt, start, stop)
// combination it clears the core's SPI register, shifts in the 16-bit config
// word, pulses the target reset and watches the target success flag for a
// fixed window. The sweep stops on the first success, holding the parameters
// for readout, or when every combination has been tried.
//
// Parameters:
//   SCK_HALF  MCLK cycles per SCK half-period and per SPI_NRST low pulse
//   RST_CYC   MCLK cycles TGT_NRST is held low per attempt
//   WIN_CYC   MCLK cycles of the observation window after TGT_NRST release
//   CNT_MAX   last clkcnt value swept (0..127)
//
// Ports:
//   MCLK      master clock
//   RST       synchronous active-high reset
//   START     one-cycle pulse, begins a sweep from idle or done
//   HIT       asynchronous target-success level
//   SPI_NRST  glitch core SPI register clear, active low
//   SPI_SCK   glitch core SPI clock
//   SPI_SDI   glitch core SPI data, MSB first
//   TGT_NRST  target reset request, active low
//   CUR_WORD  config word {1, clkcnt[6:0], stop[3:0], start[3:0]}
//   BUSY      sweep in progress
//   DONE      sweep finished
//   FOUND     sweep finished on a success
// -----------------------------------------------------------------------------
module glitch_sweep_seq #(
    parameter int SCK_HALF = 4,
    parameter int RST_CYC  = 64,
    parameter int WIN_CYC  = 65536,
    parameter int CNT_MAX  = 127
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        START,
    input  logic        HIT,
    output logic        SPI_NRST,
    output logic        SPI_SCK,
    output logic        SPI_SDI,
    output logic        TGT_NRST,
    output logic [15:0] CUR_WORD,
    output logic        BUSY,
    output logic        DONE,
    output logic        FOUND
);

    localparam int DIV_W   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    // TRST and WAIT never overlap, so they share one cycle counter.
    localparam int CYC_MAX = (WIN_CYC > RST_CYC) ? WIN_CYC : RST_CYC;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYC - 1);
    localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'(WIN_CYC - 1);
    localparam logic [6:0]       CNT_LAST = 7'(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SHIFT, S_TRST, S_WAIT, S_STEP, S_DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       hit_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       bit_q;
    logic [CYC_W-1:0] cyc_q;
    logic [6:0]       clkcnt_q;
    logic [3:0]       start_q;
    logic [3:0]       stop_q;
    logic             spi_nrst_q, sck_q, sdi_q, tgt_nrst_q;
    logic             busy_q, done_q, found_q;

    logic [6:0]       clkcnt_d;
    logic [3:0]       start_d;
    logic [3:0]       stop_d;
    logic             sweep_end;
    logic [15:0]      cur_word;

    assign cur_word = {1'b1, clkcnt_q, stop_q, start_q};

    // Two-flop synchroniser; only hit_sync_q[1] is ever looked at.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            hit_sync_q <= 2'b00;
        end else begin
            hit_sync_q <= {hit_sync_q[0], HIT};
        end
    end

    // Odometer: stop is the fastest digit, then start, then clkcnt.
    // stop restarts at the new start value so stop >= start always holds.
    always_comb begin
        clkcnt_d  = clkcnt_q;
        start_d   = start_q;
        stop_d    = stop_q;
        sweep_end = 1'b0;
        if (stop_q != 4'hF) begin
            stop_d = stop_q + 4'd1;
        end else if (start_q != 4'hF) begin
            start_d = start_q + 4'd1;
            stop_d  = start_q + 4'd1;
        end else if (clkcnt_q < CNT_LAST) begin
            clkcnt_d = clkcnt_q + 7'd1;
            start_d  = 4'd0;
            stop_d   = 4'd0;
        end else begin
            sweep_end = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            cyc_q      <= '0;
            clkcnt_q   <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            spi_nrst_q <= 1'b1;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            tgt_nrst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        clkcnt_q   <= '0;
                        start_q    <= '0;
                        stop_q     <= '0;
                        found_q    <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        spi_nrst_q <= 1'b0;
                        div_q      <= '0;
                        state_q    <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (!spi_nrst_q) begin
                        if (div_q == DIV_LAST) begin
                            spi_nrst_q <= 1'b1;
                            div_q      <= '0;
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end else begin
                        // One released cycle done; present the MSB with SCK low.
                        bit_q   <= 4'd15;
                        sdi_q   <= cur_word[15];
                        sck_q   <= 1'b0;
                        div_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            // Falling SCK edge also advances SDI.
                            sck_q <= 1'b0;
                            if (bit_q == 4'd0) begin
                                sdi_q      <= 1'b0;
                                tgt_nrst_q <= 1'b0;
                                cyc_q      <= '0;
                                state_q    <= S_TRST;
                            end else begin
                                bit_q <= bit_q - 4'd1;
                                sdi_q <= cur_word[bit_q - 4'd1];
                            end
                        end
                    end
                end
                S_TRST: begin
                    if (cyc_q == RST_LAST) begin
                        tgt_nrst_q <= 1'b1;
                        cyc_q      <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (hit_sync_q[1]) begin
                        found_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cyc_q == WIN_LAST) begin
                        state_q <= S_STEP;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                S_STEP: begin
                    if (sweep_end) begin
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        clkcnt_q   <= clkcnt_d;
                        start_q    <= start_d;
                        stop_q     <= stop_d;
                        spi_nrst_q <= 1'b0;
                        div_q      <= '0;
                        state_q    <= S_CLR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SPI_NRST = spi_nrst_q;
    assign SPI_SCK  = sck_q;
    assign SPI_SDI  = sdi_q;
    assign TGT_NRST = tgt_nrst_q;
    assign CUR_WORD = cur_word;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign FOUND    = found_q;

endmodule

// File: tb/tb_glitch_sweep_seq.sv
// -----------------------------------------------------------------------------
// tb_glitch_sweep_seq
//
// Self-checking bench for glitch_sweep_seq with small timing parameters.
// The expected config-word order is built from nested loops over
// (clkcnt, start, stop); every attempt is observed at pin level (SPI clear
// pulse, shifted bits on rising SCK, target reset length, window length).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_glitch_sweep_seq;

    localparam int SCK_HALF = 2;
    localparam int RST_CYC  = 5;
    localparam int WIN_CYC  = 8;
    localparam int CNT_MAX  = 1;
    localparam int TOTAL    = 136 * (CNT_MAX + 1);

    logic        MCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        HIT = 1'b0;
    logic        SPI_NRST, SPI_SCK, SPI_SDI, TGT_NRST;
    logic [15:0] CUR_WORD;
    logic        BUSY, DONE, FOUND;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];

    glitch_sweep_seq #(
        .SCK_HALF(SCK_HALF),
        .RST_CYC (RST_CYC),
        .WIN_CYC (WIN_CYC),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .MCLK    (MCLK),
        .RST     (RST),
        .START   (START),
        .HIT     (HIT),
        .SPI_NRST(SPI_NRST),
        .SPI_SCK (SPI_SCK),
        .SPI_SDI (SPI_SDI),
        .TGT_NRST(TGT_NRST),
        .CUR_WORD(CUR_WORD),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .FOUND   (FOUND)
    );

    always #16 MCLK = ~MCLK;

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pins"}, {SPI_NRST, SPI_SCK, SPI_SDI, TGT_NRST, BUSY, DONE, FOUND}, 7'b1001000);
        check({tag, "_word"}, CUR_WORD, 16'h8000);
    endtask

    task automatic start_sweep();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_flags", {BUSY, DONE, FOUND}, 3'b100);
        check("start_nrst", SPI_NRST, 1'b0);
        check("start_word", CUR_WORD, 16'h8000);
    endtask

    // Entry: sampled just after the edge that pulled SPI_NRST low.
    // mode 0: no HIT; 1: HIT only during SHIFT/TRST; 2: HIT in window at hit_cyc.
    // res = 1 when the sweep ended (DONE) after this attempt, 0 if the next began.
    task automatic run_attempt(input int idx, input logic [15:0] exp_word, input int mode,
                               input int hit_cyc, input bit poke_start, output int res);
        int          n;
        int          c;
        int          k;
        int          rises;
        int          last_rise;
        int          hit_at;
        bit          per_ok;
        logic        prev_sck;
        logic [15:0] bits;

        res = 0;
        // SPI register clear pulse (a START here must be ignored)
        n = 0;
        START = poke_start;
        while (SPI_NRST === 1'b0 && n < 50) begin
            n++;
            tick();
            START = 1'b0;
        end
        START = 1'b0;
        check("clr_low_len", n, SCK_HALF);

        // shift phase: capture SDI on each rising SCK
        bits = '0; rises = 0; last_rise = -1; per_ok = 1'b1;
        prev_sck = SPI_SCK; c = 0;
        hit_at = $urandom_range(2, 40);
        while (TGT_NRST === 1'b1 && c < 300) begin
            if (mode == 1 && c == hit_at) HIT = 1'b1;
            tick();
            c++;
            if (SPI_SCK === 1'b1 && prev_sck === 1'b0) begin
                bits = {bits[14:0], SPI_SDI};
                if (last_rise >= 0 && (c - last_rise) != 2 * SCK_HALF) per_ok = 1'b0;
                last_rise = c;
                rises++;
            end
            prev_sck = SPI_SCK;
        end
        check("shift_timeout", c < 300, 1'b1);
        check("sck_rises", rises, 16);
        check("sck_period", per_ok, 1'b1);
        check("shift_bits", bits, exp_word);
        check("word_attempt", CUR_WORD, exp_word);
        check("trst_idle_spi", {SPI_SCK, SPI_SDI}, 2'b00);
        check("busy_attempt", {BUSY, DONE}, 2'b10);

        // target reset pulse
        n = 0;
        while (TGT_NRST === 1'b0 && n < 200) begin
            if (mode == 1 && n == 1) HIT = 1'b0;
            n++;
            tick();
        end
        HIT = (mode == 1) ? 1'b0 : HIT;
        check("trst_len", n, RST_CYC);

        // observation window
        if (mode == 2) begin
            for (int i = 0; i < hit_cyc; i++) tick();
            HIT = 1'b1;
            k = 0;
            while (DONE !== 1'b1 && k < 6) begin
                tick();
                k++;
            end
            HIT = 1'b0;
            check("hit_latency_le3", k <= 3, 1'b1);
            check("hit_flags", {BUSY, DONE, FOUND}, 3'b011);
            check("hit_word", CUR_WORD, exp_word);
            check("hit_tgt", TGT_NRST, 1'b1);
            res = 1;
        end else begin
            c = 0;
            while (SPI_NRST === 1'b1 && DONE !== 1'b1 && c < 100) begin
                tick();
                c++;
            end
            check("window_len", c, WIN_CYC + 1);
            res = (DONE === 1'b1) ? 1 : 0;
        end
        $display("attempt %0d word=%h mode=%0d cur=%h done=%0b found=%0b",
                 idx, exp_word, mode, CUR_WORD, DONE, FOUND);
    endtask

    task automatic run_sweep(input int hit_idx, input int poke_idx);
        int idx;
        int res;
        int mode;
        start_sweep();
        idx = 0;
        res = 0;
        while (res == 0 && idx < TOTAL) begin
            if (idx == hit_idx) mode = 2;
            else mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_attempt(idx, exp_q[idx], mode, $urandom_range(0, 4), idx == poke_idx, res);
            idx++;
        end
        check("sweep_ended", res, 1);
        if (hit_idx < 0) begin
            check("sweep_attempts", idx, TOTAL);
            check("sweep_flags", {BUSY, DONE, FOUND}, 3'b010);
            check("sweep_last_word", CUR_WORD, exp_q[TOTAL-1]);
        end else begin
            check("hit_attempts", idx, hit_idx + 1);
            check("hit_final_word", CUR_WORD, exp_q[hit_idx]);
        end
        check("done_pins", {SPI_NRST, SPI_SCK, SPI_SDI, TGT_NRST}, 4'b1001);
        $display("sweep hit_idx=%0d attempts=%0d word=%h found=%0b", hit_idx, idx, CUR_WORD, FOUND);
    endtask

    initial begin
        int   res;
        int   act;
        int   rises;
        int   c;
        logic prev;

        // reference word order: stop fastest, then start, then clkcnt
        for (int cc = 0; cc <= CNT_MAX; cc++)
            for (int s = 0; s < 16; s++)
                for (int p = s; p < 16; p++)
                    exp_q.push_back({1'b1, 7'(cc), 4'(p), 4'(s)});

        // reset then long idle with noise on HIT
        RST = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        RST = 1'b0;
        act = 0;
        for (int i = 0; i < 1000; i++) begin
            HIT = 1'($urandom_range(0, 1));
            tick();
            if (SPI_SCK !== 1'b0 || TGT_NRST !== 1'b1 || SPI_NRST !== 1'b1) act++;
        end
        HIT = 1'b0;
        repeat (3) tick();
        check("idle_activity", act, 0);
        check_reset_vals("idle");
        $display("idle 1000 cycles activity=%0d", act);

        // full sweep without success; stray START mid-sweep is ignored
        run_sweep(-1, 50);
        // restart from DONE, success in attempt 140
        run_sweep(139, -1);
        check("hit140_word", CUR_WORD, 16'h8130);
        // restart from DONE, success at a random attempt
        run_sweep($urandom_range(0, 200), -1);

        // reset in the middle of SHIFT
        start_sweep();
        rises = 0; c = 0; prev = SPI_SCK;
        while (rises < 3 && c < 200) begin
            tick();
            c++;
            if (SPI_SCK === 1'b1 && prev === 1'b0) rises++;
            prev = SPI_SCK;
        end
        RST = 1'b1;
        tick();
        check_reset_vals("midshift_rst");
        RST = 1'b0;
        repeat (2) tick();
        check_reset_vals("after_rst");
        $display("reset mid-shift after %0d rises", rises);
        start_sweep();
        run_attempt(0, 16'h8000, 0, 0, 1'b0, res);
        check("restart_continue", res, 0);
        check("restart_next_word", CUR_WORD, 16'h8010);

        RST = 1'b1;
        tick();
        RST = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_seq.md
Name: glitch_sweep_seq

Overview:
- Upstream controller for the clock-glitch core.
- Walks every glitch parameter combination in turn. For each one it loads the 16-bit config word into the glitch core's SPI register, pulses target reset, then watches a success input during a fixed observation window.
- Stops on the first success (parameters held for readout) or when the sweep is exhausted.
- Runs from the 32 MHz master clock; its outputs drive the glitch core's SPI_NRST/SPI_SCK/SPI_SDI and reset pins.

Parameters:
- SCK_HALF, 4: MCLK cycles per SCK half-period and per SPI_NRST low pulse (>=1).
- RST_CYC, 64: MCLK cycles TGT_NRST is held low per attempt (>=1).
- WIN_CYC, 65536: MCLK cycles of the observation window after TGT_NRST release (>=1).
- CNT_MAX, 127: last clkcnt value swept (0..127).

Ports:
- MCLK  input  1  master clock (32 MHz).
- RST  input  1  synchronous active-high reset.
- START  input  1  one-cycle pulse; begins a sweep from IDLE or DONE; ignored otherwise.
- HIT  input  1  asynchronous target-success flag, level.
- SPI_NRST  output  1  glitch core SPI register clear, active low.
- SPI_SCK  output  1  glitch core SPI clock.
- SPI_SDI  output  1  glitch core SPI data, MSB first.
- TGT_NRST  output  1  target reset request, active low.
- CUR_WORD  output  16  config word of the current/last attempt: {1'b1, clkcnt[6:0], stop[3:0], start[3:0]}.
- BUSY  output  1  high from START acceptance until DONE.
- DONE  output  1  high in DONE state.
- FOUND  output  1  high in DONE when the sweep ended on a HIT.

Behaviour:
- Reset (synchronous, RST=1 at MCLK edge):
  - State IDLE; clkcnt=0, start=0, stop=0.
  - SPI_NRST=1, SPI_SCK=0, SPI_SDI=0, TGT_NRST=1.
  - CUR_WORD=16'h8000, BUSY=0, DONE=0, FOUND=0.
  - HIT synchroniser cleared.
  - Reset mid-sweep aborts immediately to these values.
- HIT passes a 2-flop synchroniser. Only the synchronised HIT is used; 2-cycle latency.
- States: IDLE, CLR, SHIFT, TRST, WAIT, STEP, DONE.
- IDLE/DONE, START=1:
  - Load clkcnt=0, start=0, stop=0; clear FOUND and DONE; BUSY=1; go CLR next cycle.
- CLR: SPI_NRST=0 for SCK_HALF cycles, then 1 for one cycle, then SHIFT.
- SHIFT:
  - 16 bits, bit15 first. For each bit: SDI updated on the same edge SCK falls; SCK low SCK_HALF cycles, then high SCK_HALF cycles.
  - After the 16th high phase, SCK returns to 0 and the state goes TRST. SDI then returns to 0.
  - A 4-bit bit counter tracks position; SCK_HALF uses its own divider counter.
- TRST: TGT_NRST=0 for RST_CYC cycles, then TGT_NRST=1 and go WAIT.
- WAIT: window counter runs WIN_CYC cycles.
  - Synchronised HIT=1 on any window cycle: go DONE next cycle with FOUND=1. Parameters and CUR_WORD unchanged.
  - Window expires with no HIT: go STEP.
  - HIT during CLR/SHIFT/TRST is ignored.
- STEP (one cycle), odometer order:
  - If stop<15: stop+1.
  - Else if start<15: start+1, stop=start+1.
  - Else if clkcnt<CNT_MAX: clkcnt+1, start=0, stop=0.
  - Else go DONE with FOUND=0, parameters unchanged.
  - Otherwise go CLR.
  - Invariant: stop>=start always.
- CUR_WORD updates in the cycle parameters change. bit15 is always 1.
- DONE: BUSY=0, DONE=1, TGT_NRST=1, SPI lines idle. Stays until START or RST.
- Combinations per clkcnt: 136. Total attempts: 136*(CNT_MAX+1).
- Counter widths sized from parameters (clog2). No wrap-around in any counter.

Test Plan:
- Reset then idle -> all outputs at reset values; START held 0 for 1000 cycles -> no SPI_SCK or TGT_NRST activity.
- SCK_HALF=2, START, HIT=0 -> SPI_NRST low 2 cycles; 16 SCK pulses, 4-cycle period; sampled SDI on rising SCK = 16'h8000; then TGT_NRST low RST_CYC cycles.
- CNT_MAX=0, WIN_CYC=8, HIT=0 -> exactly 136 attempts; CUR_WORD sequence 8000, 8010, ... 80F0, 8011, ..., 80FF; ends DONE=1, FOUND=0, BUSY=0.
- CNT_MAX=1, HIT asserted during window of attempt 140 -> DONE within 3 cycles of HIT rise; FOUND=1; CUR_WORD=16'h8130 (clkcnt=1, start=0, stop=3).
- HIT high only during SHIFT and TRST of an attempt -> no FOUND; sweep continues to STEP.
- RST pulsed mid-SHIFT -> next cycle all outputs at reset values; subsequent START restarts at CUR_WORD=16'h8000.
